// File: rtl/fb_pkg.sv
// Shared types and default frame geometry for the framebuffer RAM and its clear engine.
package fb_pkg;

  localparam int unsigned FB_FRAME_WIDTH     = 80;
  localparam int unsigned FB_FRAME_HEIGHT    = 60;
  localparam int unsigned FB_PIXELS_PER_WORD = 6;
  localparam int unsigned FB_DATA_WIDTH      = FB_PIXELS_PER_WORD;
  localparam int unsigned FB_LANES           = FB_PIXELS_PER_WORD;
  localparam int unsigned FB_DEPTH           = 800;
  localparam int unsigned FB_ADDR_WIDTH      = 10;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  // Words needed to hold a frame of w x h pixels packed ppw per word.
  function automatic int unsigned fb_words(input int unsigned w,
                                           input int unsigned h,
                                           input int unsigned ppw);
    return (w * h + ppw - 1) / ppw;
  endfunction

endpackage

// File: rtl/fb_clear_ctrl.sv
// Clear engine: sweeps CLEAR_VALUE across every word, owns clr_busy/clr_done and write gating.
module fb_clear_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH      = FB_DEPTH,
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int unsigned AUTO_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_ready,
  output logic                  clr_wr_en_c,
  output logic [ADDR_WIDTH-1:0] clr_wr_addr_c
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state;
  clr_state_t            state_nx;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_nx;
  logic                  auto_pend;
  logic                  start_c;
  logic                  busy_nx;
  logic                  done_nx;

  // auto_pend turns the first post-reset edge into an implicit clr_start.
  assign start_c = clr_start | auto_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLR_IDLE;
      count     <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      wr_ready  <= 1'b0;
      auto_pend <= (AUTO_CLEAR != 0);
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      clr_busy  <= busy_nx;
      clr_done  <= done_nx;
      wr_ready  <= !busy_nx;
      auto_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (start_c) begin
          state_nx = CLR_CLEAR;
          count_nx = '0;
        end
      end
      CLR_CLEAR: begin
        // Counter parks on the last word rather than wrapping through the unused range.
        if (count == LAST_ADDR) begin
          state_nx = CLR_IDLE;
          done_nx  = 1'b1;
        end else begin
          count_nx = count + ADDR_WIDTH'(1);
        end
      end
      default: state_nx = CLR_IDLE;
    endcase
    busy_nx = (state_nx == CLR_CLEAR);
  end

  assign clr_wr_en_c   = (state == CLR_CLEAR);
  assign clr_wr_addr_c = count;

endmodule

// File: rtl/framebuffer_ram.sv
// Simple dual-port lane-masked framebuffer with a built-in clear engine; read-first, 1-cycle reads.
module framebuffer_ram
  import fb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = FB_DATA_WIDTH,
  parameter int unsigned           LANES       = FB_LANES,
  parameter int unsigned           DEPTH       = FB_DEPTH,
  parameter int unsigned           ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int unsigned           AUTO_CLEAR  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LANES-1:0]      wr_mask,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int unsigned             LANE_WIDTH  = DATA_WIDTH / LANES;
  localparam int unsigned             RANGE_WIDTH = ADDR_WIDTH + 1;
  localparam logic [RANGE_WIDTH-1:0]  DEPTH_LIMIT = RANGE_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_wr_en_c;
  logic [ADDR_WIDTH-1:0] clr_wr_addr_c;
  logic                  wr_in_range_c;
  logic                  rd_in_range_c;
  logic                  user_we_c;

  fb_clear_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AUTO_CLEAR (AUTO_CLEAR)
  ) u_clear_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_start     (clr_start),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done),
    .wr_ready      (wr_ready),
    .clr_wr_en_c   (clr_wr_en_c),
    .clr_wr_addr_c (clr_wr_addr_c)
  );

  assign wr_in_range_c = ({1'b0, wr_addr} < DEPTH_LIMIT);
  assign rd_in_range_c = ({1'b0, rd_addr} < DEPTH_LIMIT);
  assign user_we_c     = wr_en & wr_ready & wr_in_range_c;

  // Single write port; clear and user writes are mutually exclusive since wr_ready drops in CLEAR.
  always_ff @(posedge clk) begin
    if (clr_wr_en_c) begin
      mem[clr_wr_addr_c] <= CLEAR_VALUE;
    end else if (user_we_c) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (wr_mask[l]) begin
          mem[wr_addr][l*LANE_WIDTH +: LANE_WIDTH] <= wr_data[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Registered read port; same-address collisions see the pre-write word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range_c ? mem[rd_addr] : CLEAR_VALUE;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_ram.sv
// Randomized self-checking bench for framebuffer_ram against an array-based reference model.
module tb_framebuffer_ram;

  localparam int unsigned DW    = 6;
  localparam int unsigned LN    = 6;
  localparam int unsigned DEPTH = 800;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [LN-1:0] wr_mask;
  logic          wr_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_rd;

  framebuffer_ram #(
    .DATA_WIDTH  (DW),
    .LANES       (LN),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .CLEAR_VALUE ('0),
    .AUTO_CLEAR  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 4) == 0) return AW'($urandom_range(DEPTH, 1023));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [LN-1:0] m);
    if (32'(a) < DEPTH) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq($sformatf("%s_rd_valid", tag), 32'(rd_valid), 32'(0));
    check_eq($sformatf("%s_rd_data", tag), 32'(rd_data), 32'(0));
    check_eq($sformatf("%s_busy", tag), 32'(clr_busy), 32'(0));
    check_eq($sformatf("%s_done", tag), 32'(clr_done), 32'(0));
    check_eq($sformatf("%s_wr_ready", tag), 32'(wr_ready), 32'(0));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0;
    model_write(a, d, m);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq("rd_valid_after_en", 32'(rd_valid), 32'(1));
    d = rd_data;
  endtask

  // Caller has already raised the start condition; cycle 1 is the first cycle after the start edge.
  task automatic clear_run(input string tag, input bit chk_rd, input int wr_at,
                           input int start_at, input bit restart);
    bit            pend;
    logic [DW-1:0] pexp;
    int            a;
    pend = 1'b0;
    pexp = '0;
    tick();
    clr_start = 1'b0;
    for (int cyc = 1; cyc <= int'(DEPTH) + 1; cyc++) begin
      check_eq($sformatf("%s_busy_c%0d", tag, cyc), 32'(clr_busy), 32'(cyc <= int'(DEPTH)));
      check_eq($sformatf("%s_ready_c%0d", tag, cyc), 32'(wr_ready), 32'(cyc > int'(DEPTH)));
      check_eq($sformatf("%s_done_c%0d", tag, cyc), 32'(clr_done), 32'(cyc == int'(DEPTH) + 1));
      if (pend) begin
        check_eq($sformatf("%s_rdv_c%0d", tag, cyc), 32'(rd_valid), 32'(1));
        check_eq($sformatf("%s_rdd_c%0d", tag, cyc), 32'(rd_data), 32'(pexp));
      end
      wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0; pend = 1'b0;
      if (cyc == int'(DEPTH) + 1) break;
      if (cyc == wr_at) begin
        wr_en = 1'b1; wr_addr = AW'(100); wr_data = 6'h3F; wr_mask = '1;
      end
      if (cyc == start_at) clr_start = 1'b1;
      if (chk_rd) begin
        a = (wr_at > 0 && cyc == wr_at + 1) ? 100 : int'($urandom_range(0, 849));
        rd_en = 1'b1; rd_addr = AW'(a);
        // Word w is cleared by the edge ending cycle w+1, so reads in cycle c see 0 for w <= c-2.
        if (a >= int'(DEPTH) || a <= cyc - 2) pexp = '0;
        else pexp = ref_mem[a];
        pend = 1'b1;
      end
      tick();
    end
    model_clear();
    if (restart) begin
      clr_start = 1'b1;
    end else begin
      tick();
      check_eq($sformatf("%s_done_once", tag), 32'(clr_done), 32'(0));
      check_eq($sformatf("%s_idle_busy", tag), 32'(clr_busy), 32'(0));
      check_eq($sformatf("%s_idle_ready", tag), 32'(wr_ready), 32'(1));
    end
  endtask

  task automatic random_phase(input int n);
    bit            we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [LN-1:0] wm;
    for (int k = 0; k < n; k++) begin
      we = 1'($urandom_range(0, 1));
      re = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wa = pick_addr();
      wd = DW'($urandom);
      wm = LN'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
      wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
      rd_en = re; rd_addr = ra;
      if (re) last_rd = (32'(ra) < DEPTH) ? ref_mem[ra] : '0;
      tick();
      if (we) model_write(wa, wd, wm);
      check_eq("rnd_rd_valid", 32'(rd_valid), 32'(re));
      check_eq("rnd_rd_data", 32'(rd_data), 32'(last_rd));
      check_eq("rnd_wr_ready", 32'(wr_ready), 32'(1));
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = 1'b1; rd_addr = AW'(5); clr_start = 1'b0;
    repeat (3) begin
      tick();
      check_reset_outputs("por");
    end
    rd_en = 1'b0;
    rst_n = 1'b1;
    clear_run("pwr_clear", 1'b0, 0, 0, 1'b0);

    // Prefill with random data, then reset and let the automatic clear wipe it.
    for (int i = 0; i < int'(DEPTH); i++) do_write(AW'(i), DW'($urandom), '1);
    rst_n = 1'b0;
    rd_en = 1'b1; rd_addr = AW'(7);
    repeat (3) begin
      tick();
      check_reset_outputs("rst");
    end
    rd_en = 1'b0;
    rst_n = 1'b1;
    clear_run("auto_clear", 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_read(AW'(i), d);
      check_eq($sformatf("auto_zero_%0d", i), 32'(d), 32'(ref_mem[i]));
    end

    // Masked write.
    do_write(AW'(5), 6'h3F, '1);
    do_write(AW'(5), 6'h00, 6'b000111);
    do_read(AW'(5), d);
    check_eq("mask_data", 32'(d), 32'(6'h38));
    tick();
    check_eq("mask_valid_drop", 32'(rd_valid), 32'(0));
    check_eq("mask_data_hold", 32'(rd_data), 32'(6'h38));

    // Read/write collision returns the old word.
    do_write(AW'(9), 6'h0A, '1);
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 6'h15; wr_mask = '1;
    rd_en = 1'b1; rd_addr = AW'(9);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    model_write(AW'(9), 6'h15, '1);
    check_eq("coll_old", 32'(rd_data), 32'(6'h0A));
    check_eq("coll_valid", 32'(rd_valid), 32'(1));
    do_read(AW'(9), d);
    check_eq("coll_new", 32'(d), 32'(6'h15));

    // Out-of-range writes are dropped and reads return the clear value.
    do_write(AW'(800), 6'h2A, '1);
    do_write(AW'(1023), 6'h2A, '1);
    do_read(AW'(800), d);
    check_eq("oob_rd_800", 32'(d), 32'(0));
    do_read(AW'(1023), d);
    check_eq("oob_rd_1023", 32'(d), 32'(0));
    do_read(AW'(0), d);
    check_eq("oob_alias_0", 32'(d), 32'(ref_mem[0]));
    do_read(AW'(223), d);
    check_eq("oob_alias_223", 32'(d), 32'(ref_mem[223]));
    do_read(AW'(799), d);
    check_eq("oob_last_word", 32'(d), 32'(ref_mem[799]));

    random_phase(1500);

    // Blocked write mid-clear, ignored restart, then back-to-back clear started on clr_done.
    do_write(AW'(100), 6'h15, '1);
    clr_start = 1'b1;
    clear_run("blk_clear", 1'b1, 10, 50, 1'b1);
    clear_run("chain_clear", 1'b1, 0, 0, 1'b0);
    do_read(AW'(100), d);
    check_eq("blk_addr100", 32'(d), 32'(0));

    // Reset in the middle of a clear aborts it with no completion pulse.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (399) tick();
    check_eq("abort_busy_before", 32'(clr_busy), 32'(1));
    rst_n = 1'b0;
    tick();
    check_reset_outputs("abort");
    repeat (2) begin
      tick();
      check_eq("abort_no_done", 32'(clr_done), 32'(0));
    end
    rst_n = 1'b1;
    clear_run("fresh_clear", 1'b1, 0, 0, 1'b0);

    random_phase(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_ram.md
FRAMEBUFFER_RAM -- requirements
Module: framebuffer_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6: bits per memory word.
REQ-002 SHALL have parameter LANES, default 6: write-mask lanes per word; DATA_WIDTH is a multiple of LANES.
REQ-003 SHALL have parameter DEPTH, default 800: number of words (800 x 6 = 80x60 frame).
REQ-004 SHALL have parameter ADDR_WIDTH, default 10: address bits; 2**ADDR_WIDTH >= DEPTH.
REQ-005 SHALL have parameter CLEAR_VALUE, default 0: word written by the clear engine.
REQ-006 SHALL have parameter AUTO_CLEAR, default 1: 1 = run a clear automatically after reset.
REQ-007 SHALL have ports: clk in 1, single clock, all logic on posedge; rst_n in 1, reset, synchronous, active-low.
REQ-008 SHALL have ports: wr_en in 1, write strobe; wr_addr in ADDR_WIDTH; wr_data in DATA_WIDTH; wr_mask in LANES, 1 = lane written; wr_ready out 1, writes accepted.
REQ-009 SHALL have ports: rd_en in 1, read strobe; rd_addr in ADDR_WIDTH; rd_data out DATA_WIDTH; rd_valid out 1, rd_data valid.
REQ-010 SHALL have ports: clr_start in 1, clear request pulse; clr_busy out 1, clear in progress; clr_done out 1, one-cycle completion pulse.

Function
REQ-011 Memory SHALL be simple dual-port: one write and one read per cycle, independent addresses.
REQ-012 Write SHALL occur at the clock edge where wr_en=1, wr_ready=1, wr_addr<DEPTH; only lanes with wr_mask bit set update; other lanes keep old data.
REQ-013 wr_en while wr_ready=0 SHALL be dropped without stall or error; the caller retries.
REQ-014 Writes with wr_addr>=DEPTH SHALL be dropped.
REQ-015 Read latency SHALL be 1 cycle: rd_en at edge N gives rd_data and rd_valid=1 after edge N; rd_valid=0 in cycles without a read; rd_data holds its last value when rd_en=0.
REQ-016 Reads with rd_addr>=DEPTH SHALL return CLEAR_VALUE with rd_valid=1.
REQ-017 A read and a write to the same address in the same cycle SHALL return the old data (read-first).
REQ-018 Reads SHALL be served in every state, including CLEAR; they return the array contents at that moment.
REQ-019 The clear FSM SHALL have two states: IDLE and CLEAR.
REQ-020 IDLE -> CLEAR SHALL occur on clr_start=1; the counter loads 0.
REQ-021 In CLEAR the engine SHALL write CLEAR_VALUE, all lanes, to address counter each cycle; after DEPTH cycles it returns to IDLE; the counter ends at DEPTH-1, not 2**ADDR_WIDTH-1.
REQ-022 clr_busy SHALL be 1 exactly in CLEAR, and wr_ready SHALL equal not clr_busy.
REQ-023 clr_done SHALL pulse 1 for the single cycle after the final clear write.
REQ-024 clr_start during CLEAR SHALL be ignored; clr_start in the cycle of clr_done SHALL start a new clear.
REQ-025 A clear, start to clr_done, SHALL take exactly DEPTH+1 cycles.

Reset
REQ-026 While rst_n=0: state IDLE, counter 0, rd_data 0, rd_valid 0, clr_busy 0, clr_done 0, wr_ready 0; array contents not reset.
REQ-027 With AUTO_CLEAR=1, the first edge with rst_n=1 SHALL enter CLEAR as if clr_start were asserted; with AUTO_CLEAR=0 it SHALL stay IDLE with wr_ready=1.
REQ-028 rst_n=0 mid-clear SHALL abort the clear immediately; no clr_done is generated for the aborted run.

Structure
REQ-029 Package fb_pkg SHALL hold the clear-FSM state enum and the default frame constants (80, 60, 6, 800, 10).
REQ-030 Sub-module fb_clear_ctrl SHALL implement the FSM, counter, clr_busy/clr_done and clear write port; the array stays in framebuffer_ram and is inferable as block RAM.

Verification
REQ-031 Auto clear: AUTO_CLEAR=1, prefill, reset 3 cycles -> clr_busy for 800 cycles, clr_done once at cycle 801, all 800 reads = 0.
REQ-032 Masked write: write 6'h3F to addr 5, then 6'h00 with mask 6'b000111 -> read addr 5 = 6'h38, rd_valid 1 cycle after rd_en.
REQ-033 Collision: addr 9 holds 6'h0A; write 6'h15 and read addr 9 in the same cycle -> 6'h0A, next read -> 6'h15.
REQ-034 Blocked write: clr_start, then wr_en to addr 100 at clear cycle 10 -> after clr_done addr 100 reads 0; second clr_start at cycle 50 ignored, clr_done still at cycle 801.
REQ-035 Bounds: write 6'h2A to addr 800 and 1023 -> no array change; reads of 800 and 1023 return 0 with rd_valid=1.
REQ-036 Abort: rst_n=0 at clear cycle 400 -> clr_busy 0, no clr_done; on release a fresh 800-cycle clear runs.
